// File: rtl/dsp_mode_sequencer.sv
// dsp_mode_sequencer
// Decides which DSP engine (FIR or TEA) owns the shared Avalon-ST path.
// Mode changes are deferred to packet boundaries. New packets are held off
// at the sink, the active engine is drained of in-flight packets, and only
// then is the new selection loaded. The number of packets in flight is
// capped at MAX_OUTSTANDING.

module dsp_mode_sequencer #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fir_enable_req,
    input  logic             tea_enable_req,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic             engine_sink_ready,
    output logic             sink_ready_gated,
    input  logic             source_valid,
    input  logic             source_ready,
    input  logic             source_eop,
    output logic             sel_fir,
    output logic             sel_tea,
    output logic             busy,
    output logic             switch_done,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_underflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN,
        ST_SWITCH
    } state_t;

    typedef enum logic [1:0] {
        MODE_NONE,
        MODE_FIR,
        MODE_TEA
    } mode_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t           state;
    state_t           state_next;
    mode_t            req_mode;
    mode_t            cur_mode;
    logic             change_pending;
    logic             sink_acc;
    logic             src_eop_acc;
    logic             in_pkt;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_next;
    logic             underflow;

    // Decode the CSR request (FIR has priority) and the current selection.
    // NOTE: every signal driven from always_comb gets a default assignment
    // first so that no path leaves it unassigned and infers a latch.
    always_comb begin
        req_mode = MODE_NONE;
        if (fir_enable_req) begin
            req_mode = MODE_FIR;
        end else if (tea_enable_req) begin
            req_mode = MODE_TEA;
        end

        cur_mode = MODE_NONE;
        if (sel_fir) begin
            cur_mode = MODE_FIR;
        end else if (sel_tea) begin
            cur_mode = MODE_TEA;
        end
    end

    assign change_pending = (req_mode != cur_mode);
    assign sink_acc       = sink_valid & sink_ready_gated;
    assign src_eop_acc    = source_valid & source_ready & source_eop;
    assign cnt_inc        = sink_acc & sink_sop;
    assign cnt_dec        = src_eop_acc;

    // Next outstanding count; a decrement at zero clamps and flags underflow.
    always_comb begin
        cnt_next  = outstanding;
        underflow = 1'b0;
        if (cnt_inc && !cnt_dec) begin
            cnt_next = outstanding + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc) begin
            if (outstanding == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_next = outstanding - CNT_W'(1);
            end
        end
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: switch only at packet boundaries after a full drain.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_mode != MODE_NONE) state_next = ST_SWITCH;
            end
            ST_ACTIVE: begin
                if (change_pending && !in_pkt) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Uses the post-update count so the last source eop is enough.
                if (cnt_next == '0) state_next = ST_SWITCH;
            end
            ST_SWITCH: begin
                state_next = (req_mode == MODE_NONE) ? ST_IDLE : ST_ACTIVE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State-derived outputs: busy flag and the upstream ready gate.
    always_comb begin
        busy             = (state == ST_DRAIN) || (state == ST_SWITCH);
        sink_ready_gated = engine_sink_ready && (state == ST_ACTIVE) &&
                           (in_pkt || (!change_pending && (outstanding < MAX_CNT)));
    end

    // Selection register, loaded only in SWITCH, plus the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_fir     <= 1'b0;
            sel_tea     <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            switch_done <= (state == ST_SWITCH);
            if (state == ST_SWITCH) begin
                sel_fir <= (req_mode == MODE_FIR);
                sel_tea <= (req_mode == MODE_TEA);
            end
        end
    end

    // Packet tracking: mid-packet flag, outstanding count, sticky underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt        <= 1'b0;
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (sink_acc && sink_eop) begin
                in_pkt <= 1'b0;
            end else if (sink_acc && sink_sop) begin
                in_pkt <= 1'b1;
            end
            outstanding <= cnt_next;
            if (underflow) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsp_mode_sequencer.sv
// Testbench for dsp_mode_sequencer: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.

module tb_dsp_mode_sequencer;

    localparam int MAX_OUT = 4;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             rst_n;
    logic             fir_enable_req;
    logic             tea_enable_req;
    logic             sink_valid;
    logic             sink_sop;
    logic             sink_eop;
    logic             engine_sink_ready;
    logic             sink_ready_gated;
    logic             source_valid;
    logic             source_ready;
    logic             source_eop;
    logic             sel_fir;
    logic             sel_tea;
    logic             busy;
    logic             switch_done;
    logic [CNT_W-1:0] outstanding;
    logic             err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    dsp_mode_sequencer #(
        .MAX_OUTSTANDING(MAX_OUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fir_enable_req   (fir_enable_req),
        .tea_enable_req   (tea_enable_req),
        .sink_valid       (sink_valid),
        .sink_sop         (sink_sop),
        .sink_eop         (sink_eop),
        .engine_sink_ready(engine_sink_ready),
        .sink_ready_gated (sink_ready_gated),
        .source_valid     (source_valid),
        .source_ready     (source_ready),
        .source_eop       (source_eop),
        .sel_fir          (sel_fir),
        .sel_tea          (sel_tea),
        .busy             (busy),
        .switch_done      (switch_done),
        .outstanding      (outstanding),
        .err_underflow    (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic fir, tea, sv, sop, eop, eng, srcv, srcr, srceop;
        logic exp_rdy, exp_fir, exp_tea, exp_busy, exp_done;
        int   exp_cnt;
        logic exp_err;
    } vec_t;

    vec_t vecs[16];

    // Behavioural model: selection as 0=none/1=FIR/2=TEA, phase flags.
    int m_sel, m_cnt;
    bit m_on, m_drain, m_swap, m_in_pkt, m_err, m_done;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic fir, input logic tea, input logic sv,
                          input logic sop, input logic eop, input logic eng,
                          input logic srcv, input logic srcr, input logic srceop);
        fir_enable_req    = fir;
        tea_enable_req    = tea;
        sink_valid        = sv;
        sink_sop          = sop;
        sink_eop          = eop;
        engine_sink_ready = eng;
        source_valid      = srcv;
        source_ready      = srcr;
        source_eop        = srceop;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_sel = 0; m_cnt = 0;
        m_on = 0; m_drain = 0; m_swap = 0; m_in_pkt = 0; m_err = 0; m_done = 0;
    endtask

    function automatic int req_of(input logic fir, input logic tea);
        return fir ? 1 : (tea ? 2 : 0);
    endfunction

    function automatic bit model_ready();
        int req = req_of(fir_enable_req, tea_enable_req);
        return engine_sink_ready && m_on && (m_in_pkt || (req == m_sel && m_cnt < MAX_OUT));
    endfunction

    // Compare every output with the model, then advance the model one clock.
    task automatic model_check_and_step();
        int req;
        bit rdy, acc, eop_acc;
        int n_cnt;
        req     = req_of(fir_enable_req, tea_enable_req);
        rdy     = model_ready();
        check("rnd_ready", int'(sink_ready_gated), int'(rdy));
        check("rnd_sel_fir", int'(sel_fir), int'(m_sel == 1));
        check("rnd_sel_tea", int'(sel_tea), int'(m_sel == 2));
        check("rnd_busy", int'(busy), int'(m_drain || m_swap));
        check("rnd_done", int'(switch_done), int'(m_done));
        check("rnd_outstanding", int'(outstanding), m_cnt);
        check("rnd_err", int'(err_underflow), int'(m_err));

        acc     = sink_valid && rdy;
        eop_acc = source_valid && source_ready && source_eop;
        n_cnt   = m_cnt + int'(acc && sink_sop) - int'(eop_acc);
        if (n_cnt < 0) begin
            n_cnt = 0;
            m_err = 1;
        end
        m_done = m_swap;
        if (m_swap) begin
            m_sel  = req;
            m_on   = (req != 0);
            m_swap = 0;
        end else if (m_drain) begin
            if (n_cnt == 0) begin
                m_drain = 0;
                m_swap  = 1;
            end
        end else if (m_on) begin
            if (req != m_sel && !m_in_pkt) begin
                m_on    = 0;
                m_drain = 1;
            end
        end else if (req != 0) begin
            m_swap = 1;
        end
        if (acc && sink_eop) m_in_pkt = 0;
        else if (acc && sink_sop) m_in_pkt = 1;
        m_cnt = n_cnt;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // fir tea sv sop eop eng srcv srcr srceop | rdy sf st busy done cnt err
        vecs[0]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
        vecs[1]  = '{1,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0};
        vecs[2]  = '{1,0,0,0,0,1,0,0,0, 0,0,0,1,0,0,0};
        vecs[3]  = '{1,0,1,1,0,1,0,0,0, 1,1,0,0,1,0,0};
        vecs[4]  = '{1,0,1,0,0,0,0,0,0, 0,1,0,0,0,1,0};
        vecs[5]  = '{0,1,1,0,0,1,0,0,0, 1,1,0,0,0,1,0};
        vecs[6]  = '{0,1,1,0,1,1,0,0,0, 1,1,0,0,0,1,0};
        vecs[7]  = '{0,1,1,1,0,1,0,0,0, 0,1,0,0,0,1,0};
        vecs[8]  = '{0,1,1,1,0,1,0,0,0, 0,1,0,1,0,1,0};
        vecs[9]  = '{0,1,0,0,0,1,1,1,1, 0,1,0,1,0,1,0};
        vecs[10] = '{0,1,0,0,0,1,0,0,0, 0,1,0,1,0,0,0};
        vecs[11] = '{0,1,0,0,0,1,0,0,0, 1,0,1,0,1,0,0};
        vecs[12] = '{0,1,0,0,0,0,0,0,0, 0,0,1,0,0,0,0};
        vecs[13] = '{0,1,0,0,0,1,1,1,1, 1,0,1,0,0,0,0};
        vecs[14] = '{0,1,0,0,0,1,0,0,0, 1,0,1,0,0,0,1};
        vecs[15] = '{0,1,0,0,0,0,0,0,0, 0,0,1,0,0,0,1};

        // Directed table: bring-up, mid-packet change, drain, underflow.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_in(vecs[i].fir, vecs[i].tea, vecs[i].sv, vecs[i].sop, vecs[i].eop,
                   vecs[i].eng, vecs[i].srcv, vecs[i].srcr, vecs[i].srceop);
            #1;
            check($sformatf("vec%0d_ready", i), int'(sink_ready_gated), int'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_sel_fir", i), int'(sel_fir), int'(vecs[i].exp_fir));
            check($sformatf("vec%0d_sel_tea", i), int'(sel_tea), int'(vecs[i].exp_tea));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i), int'(switch_done), int'(vecs[i].exp_done));
            check($sformatf("vec%0d_outstanding", i), int'(outstanding), vecs[i].exp_cnt);
            check($sformatf("vec%0d_err", i), int'(err_underflow), int'(vecs[i].exp_err));
        end

        // Outstanding limit: four single-beat packets with the source stalled.
        do_reset();
        @(negedge clk); set_in(0, 1, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); set_in(0, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < MAX_OUT; i++) begin
            @(negedge clk); set_in(0, 1, 1, 1, 1, 1, 0, 0, 0); #1;
            check($sformatf("lim_ready_%0d", i), int'(sink_ready_gated), 1);
            check($sformatf("lim_cnt_%0d", i), int'(outstanding), i);
        end
        @(negedge clk); set_in(0, 1, 1, 1, 1, 1, 0, 0, 0); #1;
        check("lim_full_ready", int'(sink_ready_gated), 0);
        check("lim_full_cnt", int'(outstanding), MAX_OUT);
        @(negedge clk); set_in(0, 1, 1, 1, 1, 1, 1, 1, 1); #1;
        check("lim_full_eop_ready", int'(sink_ready_gated), 0);
        @(negedge clk); set_in(0, 1, 1, 1, 1, 1, 1, 1, 1); #1;
        check("lim_reopen_ready", int'(sink_ready_gated), 1);
        check("lim_reopen_cnt", int'(outstanding), MAX_OUT - 1);
        @(negedge clk); set_in(0, 1, 1, 1, 1, 1, 0, 0, 0); #1;
        check("lim_simul_cnt", int'(outstanding), MAX_OUT - 1);
        @(negedge clk); set_in(0, 1, 0, 0, 0, 1, 0, 0, 0); #1;
        check("lim_refill_cnt", int'(outstanding), MAX_OUT);
        check("lim_refill_ready", int'(sink_ready_gated), 0);
        check("lim_no_err", int'(err_underflow), 0);

        // Asynchronous reset while draining two packets.
        do_reset();
        @(negedge clk); set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); set_in(1, 0, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk); set_in(1, 0, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk); set_in(0, 1, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); set_in(0, 1, 0, 0, 0, 1, 0, 0, 0); #1;
        check("rst_pre_busy", int'(busy), 1);
        check("rst_pre_cnt", int'(outstanding), 2);
        check("rst_pre_sel_fir", int'(sel_fir), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_sel_fir", int'(sel_fir), 0);
        check("rst_async_sel_tea", int'(sel_tea), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_cnt", int'(outstanding), 0);
        check("rst_async_done", int'(switch_done), 0);
        check("rst_async_err", int'(err_underflow), 0);
        check("rst_async_ready", int'(sink_ready_gated), 0);

        // Randomized traffic against the behavioural model.
        for (int blk = 0; blk < 6; blk++) begin
            logic fir_r, tea_r;
            do_reset();
            fir_r = 1'b0;
            tea_r = 1'b0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                if ($urandom_range(15) == 0) begin
                    fir_r = 1'($urandom_range(1));
                    tea_r = 1'($urandom_range(1));
                end
                set_in(fir_r, tea_r,
                       $urandom_range(9) < 7, $urandom_range(9) < 3, $urandom_range(9) < 4,
                       $urandom_range(3) != 0,
                       $urandom_range(1) == 1, $urandom_range(9) < 6, $urandom_range(9) < 3);
                #1;
                model_check_and_step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
